// File: rtl/regbank_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_sequencer_pkg
// Purpose  : Shared encodings for the register-bank sequencer. The register
//            bank uses the same encodings.
//            - op_kind codes coming from instruction decode
//            - regbank_control codes driven toward the register bank
//            - 3-bit sequencer state encoding
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regbank_sequencer_pkg;

    // Decoded instruction kinds (op_kind input)
    localparam logic [2:0] c_op_nop        = 3'd0;
    localparam logic [2:0] c_op_alu        = 3'd1;
    localparam logic [2:0] c_op_load       = 3'd2;
    localparam logic [2:0] c_op_store      = 3'd3;
    localparam logic [2:0] c_op_swi        = 3'd4;
    localparam logic [2:0] c_op_rfe        = 3'd5;
    localparam logic [2:0] c_op_bank_clear = 3'd6;
    localparam logic [2:0] c_op_reserved   = 3'd7;

    // Register bank commit controls (regbank_control output)
    localparam logic [2:0] c_ctl_none      = 3'd0;
    localparam logic [2:0] c_ctl_alu_rd    = 3'd1;
    localparam logic [2:0] c_ctl_clear     = 3'd2;
    localparam logic [2:0] c_ctl_mem_rd    = 3'd3;
    localparam logic [2:0] c_ctl_enter_prv = 3'd4;

    // Sequencer state encoding
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_commit     = 3'd1;
    localparam logic [2:0] c_st_mem_wait   = 3'd2;
    localparam logic [2:0] c_st_mem_commit = 3'd3;
    localparam logic [2:0] c_st_trap       = 3'd4;

endpackage : regbank_sequencer_pkg
`default_nettype wire

// File: rtl/regbank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regbank_sequencer
// Purpose  : Per-instruction sequencer for the register bank. It owns the
//            privilege bit, the data-memory wait handshake with timeout, and
//            trap entry (SWI, IRQ, memory timeout).
// Ports    :
//   clock           in   single clock, all state updates on posedge
//   reset           in   synchronous, active-low reset
//   instr_valid     in   decoded instruction available
//   op_kind         in   [2:0] instruction kind (see package codes)
//   irq             in   level interrupt request
//   irq_enable      in   global interrupt mask
//   mem_ready       in   data memory completes the current access
//   instr_ack       out  instruction consumed this cycle
//   mem_request     out  data access outstanding
//   regbank_enable  out  register bank commit strobe
//   regbank_control out  [2:0] commit control (see package codes)
//   privileged_mode out  selects the privileged stack pointer in the bank
//   busy            out  sequencer not idle
//   fault           out  sticky memory-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module regbank_sequencer
    import regbank_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [2:0] op_kind,
    input  logic       irq,
    input  logic       irq_enable,
    input  logic       mem_ready,
    output logic       instr_ack,
    output logic       mem_request,
    output logic       regbank_enable,
    output logic [2:0] regbank_control,
    output logic       privileged_mode,
    output logic       busy,
    output logic       fault
);

    // Last wait count before the access is declared timed out
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [2:0]           r_state;
    logic [2:0]           r_op_q;
    logic [CNT_WIDTH-1:0] r_wait_cnt;
    logic                 r_priv;
    logic                 r_fault;

    logic                 w_idle;
    logic                 w_irq_take;
    logic                 w_accept;

    // Interrupts are only taken from user mode; an instruction presented in
    // the same cycle is left unacknowledged and retried after the trap.
    assign w_idle     = (r_state == c_st_idle);
    assign w_irq_take = irq & irq_enable & ~r_priv;
    assign w_accept   = w_idle & ~w_irq_take & instr_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_op_q     <= c_op_nop;
            r_wait_cnt <= '0;
            r_priv     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_irq_take) begin
                        r_state <= c_st_trap;
                    end else if (instr_valid) begin
                        r_op_q <= op_kind;
                        case (op_kind)
                            c_op_load, c_op_store: begin
                                r_state    <= c_st_mem_wait;
                                r_wait_cnt <= '0;
                            end
                            c_op_swi: r_state <= c_st_trap;
                            default:  r_state <= c_st_commit;
                        endcase
                    end
                end
                c_st_commit: begin
                    // Return from exception drops privilege as it retires
                    if (r_op_q == c_op_rfe) begin
                        r_priv <= 1'b0;
                    end
                    r_state <= c_st_idle;
                end
                c_st_mem_wait: begin
                    // mem_ready takes precedence over a coincident timeout
                    if (mem_ready) begin
                        r_state <= (r_op_q == c_op_load) ? c_st_mem_commit : c_st_commit;
                    end else if (r_wait_cnt == c_cnt_last) begin
                        r_fault <= 1'b1;
                        r_state <= c_st_trap;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_one;
                    end
                end
                c_st_mem_commit: begin
                    r_state <= c_st_idle;
                end
                c_st_trap: begin
                    r_priv  <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Moore commit outputs decoded from state and the latched op
    always_comb begin
        regbank_enable  = 1'b0;
        regbank_control = c_ctl_none;
        case (r_state)
            c_st_commit: begin
                regbank_enable = 1'b1;
                if (r_op_q == c_op_alu) begin
                    regbank_control = c_ctl_alu_rd;
                end else if (r_op_q == c_op_bank_clear) begin
                    regbank_control = c_ctl_clear;
                end
            end
            c_st_mem_commit: begin
                regbank_enable  = 1'b1;
                regbank_control = c_ctl_mem_rd;
            end
            c_st_trap: begin
                regbank_enable  = 1'b1;
                regbank_control = c_ctl_enter_prv;
            end
            default: begin
                regbank_enable  = 1'b0;
                regbank_control = c_ctl_none;
            end
        endcase
    end

    assign instr_ack       = w_accept;
    assign mem_request     = (r_state == c_st_mem_wait);
    assign busy            = ~w_idle;
    assign privileged_mode = r_priv;
    assign fault           = r_fault;

endmodule : regbank_sequencer
`default_nettype wire

// File: tb/tb_regbank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_sequencer
// Purpose  : Directed self-checking bench for regbank_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_sequencer;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_WIDTH   = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [2:0] op_kind;
    logic       irq;
    logic       irq_enable;
    logic       mem_ready;
    logic       instr_ack;
    logic       mem_request;
    logic       regbank_enable;
    logic [2:0] regbank_control;
    logic       privileged_mode;
    logic       busy;
    logic       fault;

    int total = 0;
    int bad   = 0;

    regbank_sequencer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .op_kind        (op_kind),
        .irq            (irq),
        .irq_enable     (irq_enable),
        .mem_ready      (mem_ready),
        .instr_ack      (instr_ack),
        .mem_request    (mem_request),
        .regbank_enable (regbank_enable),
        .regbank_control(regbank_control),
        .privileged_mode(privileged_mode),
        .busy           (busy),
        .fault          (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1ns later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present an instruction in IDLE, expect it to be acked, then drop it
    task automatic accept(input logic [2:0] op, input string tag);
        instr_valid = 1'b1;
        op_kind     = op;
        #1;
        check({tag, "_ack"}, {7'd0, instr_ack}, 8'd1);
        tick();
        instr_valid = 1'b0;
        op_kind     = 3'd0;
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        op_kind     = 3'd0;
        irq         = 1'b0;
        irq_enable  = 1'b0;
        mem_ready   = 1'b0;
        tick();
        tick();
        check("rst_busy",  {7'd0, busy},            8'd0);
        check("rst_en",    {7'd0, regbank_enable},  8'd0);
        check("rst_req",   {7'd0, mem_request},     8'd0);
        check("rst_priv",  {7'd0, privileged_mode}, 8'd0);
        check("rst_fault", {7'd0, fault},           8'd0);
        reset = 1'b1;
        tick();

        // ALU: commit next cycle with control 1, then idle
        accept(3'd1, "alu");
        check("alu_en",   {7'd0, regbank_enable}, 8'd1);
        check("alu_ctl",  {5'd0, regbank_control}, 8'd1);
        check("alu_ack2", {7'd0, instr_ack}, 8'd0);
        tick();
        check("alu_idle", {7'd0, busy}, 8'd0);
        check("alu_en0",  {7'd0, regbank_enable}, 8'd0);

        // LOAD: ready on third wait cycle
        accept(3'd2, "ld");
        check("ld_req1", {7'd0, mem_request}, 8'd1);
        check("ld_en1",  {7'd0, regbank_enable}, 8'd0);
        tick();
        check("ld_req2", {7'd0, mem_request}, 8'd1);
        tick();
        mem_ready = 1'b1;
        check("ld_req3", {7'd0, mem_request}, 8'd1);
        tick();
        mem_ready = 1'b0;
        check("ld_en",    {7'd0, regbank_enable}, 8'd1);
        check("ld_ctl",   {5'd0, regbank_control}, 8'd3);
        check("ld_req0",  {7'd0, mem_request}, 8'd0);
        check("ld_fault", {7'd0, fault}, 8'd0);
        tick();
        check("ld_idle", {7'd0, busy}, 8'd0);

        // STORE: immediate ready, commit with control 0
        accept(3'd3, "st");
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("st_en",  {7'd0, regbank_enable}, 8'd1);
        check("st_ctl", {5'd0, regbank_control}, 8'd0);
        tick();

        // BANK_CLEAR: control 2
        accept(3'd6, "clr");
        check("clr_en",  {7'd0, regbank_enable}, 8'd1);
        check("clr_ctl", {5'd0, regbank_control}, 8'd2);
        tick();

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rdy_idle_busy", {7'd0, busy}, 8'd0);
        check("rdy_idle_en",   {7'd0, regbank_enable}, 8'd0);

        // Reset during MEM_WAIT abandons the access
        accept(3'd2, "rstw");
        check("rstw_req", {7'd0, mem_request}, 8'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rstw_busy", {7'd0, busy}, 8'd0);
        check("rstw_req0", {7'd0, mem_request}, 8'd0);
        check("rstw_en",   {7'd0, regbank_enable}, 8'd0);
        check("rstw_flt",  {7'd0, fault}, 8'd0);
        check("rstw_priv", {7'd0, privileged_mode}, 8'd0);
        tick();
        check("rstw_en2", {7'd0, regbank_enable}, 8'd0);

        // RFE in user mode: plain commit, stays user
        accept(3'd5, "rfeu");
        check("rfeu_ctl", {5'd0, regbank_control}, 8'd0);
        tick();
        check("rfeu_priv", {7'd0, privileged_mode}, 8'd0);

        // SWI then RFE
        accept(3'd4, "swi");
        check("swi_en",    {7'd0, regbank_enable}, 8'd1);
        check("swi_ctl",   {5'd0, regbank_control}, 8'd4);
        check("swi_priv0", {7'd0, privileged_mode}, 8'd0);
        tick();
        check("swi_priv", {7'd0, privileged_mode}, 8'd1);
        check("swi_idle", {7'd0, busy}, 8'd0);
        accept(3'd5, "rfe");
        check("rfe_en",    {7'd0, regbank_enable}, 8'd1);
        check("rfe_ctl",   {5'd0, regbank_control}, 8'd0);
        check("rfe_priv1", {7'd0, privileged_mode}, 8'd1);
        tick();
        check("rfe_priv", {7'd0, privileged_mode}, 8'd0);

        // IRQ beats a simultaneous instruction in user mode
        irq         = 1'b1;
        irq_enable  = 1'b1;
        instr_valid = 1'b1;
        op_kind     = 3'd1;
        #1;
        check("irq_ack0", {7'd0, instr_ack}, 8'd0);
        tick();
        check("irq_en",  {7'd0, regbank_enable}, 8'd1);
        check("irq_ctl", {5'd0, regbank_control}, 8'd4);
        check("irq_ack_trap", {7'd0, instr_ack}, 8'd0);
        tick();
        check("irq_priv", {7'd0, privileged_mode}, 8'd1);
        check("irq_held_ack", {7'd0, instr_ack}, 8'd1);
        tick();
        instr_valid = 1'b0;
        irq         = 1'b0;
        check("irq_held_ctl", {5'd0, regbank_control}, 8'd1);
        tick();
        accept(3'd5, "irq_rfe");
        tick();
        check("irq_rfe_priv", {7'd0, privileged_mode}, 8'd0);

        // mem_ready on the last allowed wait cycle still succeeds
        accept(3'd2, "edge");
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
        mem_ready = 1'b1;
        check("edge_req", {7'd0, mem_request}, 8'd1);
        tick();
        mem_ready = 1'b0;
        check("edge_ctl",   {5'd0, regbank_control}, 8'd3);
        check("edge_fault", {7'd0, fault}, 8'd0);
        tick();

        // Timeout: 16 wait cycles then fault and trap
        accept(3'd2, "tmo");
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            check("tmo_req", {7'd0, mem_request}, 8'd1);
            check("tmo_flt0", {7'd0, fault}, 8'd0);
            tick();
        end
        check("tmo_fault", {7'd0, fault}, 8'd1);
        check("tmo_en",    {7'd0, regbank_enable}, 8'd1);
        check("tmo_ctl",   {5'd0, regbank_control}, 8'd4);
        tick();
        check("tmo_priv", {7'd0, privileged_mode}, 8'd1);
        check("tmo_idle", {7'd0, busy}, 8'd0);

        // fault is sticky across further instructions; reset clears it
        accept(3'd1, "stk");
        tick();
        check("stk_fault", {7'd0, fault}, 8'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("clr_fault", {7'd0, fault}, 8'd0);
        check("clr_priv",  {7'd0, privileged_mode}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regbank_sequencer
`default_nettype wire
